// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory write port,
// big-endian (MSB at the word address), one byte per cycle.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 512,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             word_valid,
    input  logic [31:0]      word_data,
    input  logic             word_last,
    output logic             word_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [1:0] {StIdle, StWait, StWrite, StDone} state_e;

    localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

    state_e           state_q, state_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      word_q, word_d;
    logic             last_q, last_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [32:0]      ptr_end;
    logic [7:0]       byte_sel;

    // Widened so a base near 2^32 cannot wrap past the bound check.
    assign ptr_end = {1'b0, ptr_q} + 33'd4;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d   = {base_addr[31:2], 2'b00};
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (word_valid) begin
                    if (ptr_end > MemLimit) begin
                        ovf_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        word_d  = word_data;
                        last_d  = word_last;
                        idx_d   = 2'd0;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    ptr_d   = ptr_q + 32'd4;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_q ? StDone : StWait;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        byte_sel = word_q[31:24];
        unique case (idx_q)
            2'd0: byte_sel = word_q[31:24];
            2'd1: byte_sel = word_q[23:16];
            2'd2: byte_sel = word_q[15:8];
            2'd3: byte_sel = word_q[7:0];
            default: byte_sel = word_q[31:24];
        endcase
    end

    // Address/data are forced to zero outside WRITE so the port is quiet when idle.
    assign word_ready   = (state_q == StWait);
    assign wr_en        = (state_q == StWrite);
    assign wr_addr      = wr_en ? (ptr_q + {30'd0, idx_q}) : 32'd0;
    assign wr_data      = wr_en ? byte_sel : 8'd0;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign overflow     = ovf_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: logs every byte write and handshake, compares against
// expected big-endian byte streams built from the words each test sends.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] words_loaded;

    imem_loader #(.MEM_BYTES(512), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_last    (word_last),
        .word_ready   (word_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];
    int          hs_q[$];
    int          dn_cnt;
    int          dn_cyc;
    logic [31:0] exp_words[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done) begin
            dn_cnt = dn_cnt + 1;
            dn_cyc = cyc;
        end
        if (word_ready && word_valid) hs_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        hs_q.delete();
        exp_words.delete();
        dn_cnt = 0;
        dn_cyc = 0;
    endtask

    // Called #1 after a rising edge while IDLE.
    task automatic do_start(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Presents a word and waits for the handshake; returns #1 after the edge following it.
    task automatic send_word(input string tag, input logic [31:0] d, input logic l,
                             input logic exp_wr);
        logic got;
        got        = 1'b0;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = l;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (word_ready) begin
                got = 1'b1;
                break;
            end
        end
        check_eq({tag, "_hs"}, {31'd0, got}, 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq({tag, "_lat"}, {31'd0, wr_en}, {31'd0, exp_wr});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Expected stream: every word in exp_words, MSB first, from base upward.
    task automatic check_writes(input string tag, input logic [31:0] base);
        int n;
        logic [31:0] w;
        n = exp_words.size() * 4;
        check_eq({tag, "_nwr"}, wa_q.size(), n);
        if (wa_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                w = exp_words[i / 4];
                check_eq($sformatf("%s_a%0d", tag, i), wa_q[i], base + i);
                check_eq($sformatf("%s_d%0d", tag, i), {24'd0, wd_q[i]},
                         {24'd0, 8'(w >> (8 * (3 - (i % 4))))});
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctl", {27'd0, word_ready, wr_en, busy, done, overflow}, 32'd0);
        check_eq("rst_addr", wr_addr, 32'd0);
        check_eq("rst_cnt", {16'd0, words_loaded}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single word at 0, hand-written expected bytes
        clear_logs();
        do_start(32'h0);
        send_word("t1", 32'h8000_0098, 1'b1, 1'b1);
        word_valid = 1'b0;
        wait_idle("t1");
        check_eq("t1_n", wa_q.size(), 4);
        if (wa_q.size() == 4) begin
            check_eq("t1_b0", {wa_q[0], wd_q[0]} , {32'd0, 8'h80});
            check_eq("t1_b3", {wa_q[3], wd_q[3]} , {32'd3, 8'h98});
            check_eq("t1_b12", {wd_q[1], wd_q[2]}, 16'h0000);
            check_eq("t1_consec", wc_q[3] - wc_q[0], 3);
            check_eq("t1_done_at", dn_cyc, wc_q[3] + 1);
        end
        check_eq("t1_dn", dn_cnt, 1);
        check_eq("t1_cnt", {16'd0, words_loaded}, 32'd1);
        check_eq("t1_ovf", {31'd0, overflow}, 32'd0);

        // 2: unaligned base, back-to-back words
        clear_logs();
        exp_words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        do_start(32'h13);
        send_word("t2a", 32'h1122_3344, 1'b0, 1'b1);
        send_word("t2b", 32'h5566_7788, 1'b0, 1'b1);
        send_word("t2c", 32'h99AA_BBCC, 1'b1, 1'b1);
        word_valid = 1'b0;
        wait_idle("t2");
        check_writes("t2", 32'h10);
        check_eq("t2_nhs", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check_eq("t2_gap0", hs_q[1] - hs_q[0], 5);
            check_eq("t2_gap1", hs_q[2] - hs_q[1], 5);
        end
        check_eq("t2_cnt", {16'd0, words_loaded}, 32'd3);

        // 3: word ending at 511 accepted, next one overflows
        clear_logs();
        exp_words = '{32'hA1B2_C3D4};
        do_start(32'd508);
        send_word("t3a", 32'hA1B2_C3D4, 1'b0, 1'b1);
        send_word("t3b", 32'hFFFF_FFFF, 1'b1, 1'b0);
        word_valid = 1'b0;
        wait_idle("t3");
        check_writes("t3", 32'd508);
        check_eq("t3_ovf", {31'd0, overflow}, 32'd1);
        check_eq("t3_dn", dn_cnt, 1);
        check_eq("t3_cnt", {16'd0, words_loaded}, 32'd1);

        // 4: long stall in WAIT, then a normal word; start also clears overflow
        clear_logs();
        exp_words = '{32'h0123_4567};
        do_start(32'h40);
        check_eq("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("t4_stall_wr", wa_q.size(), 0);
        check_eq("t4_stall_st", {30'd0, busy, word_ready}, 32'd3);
        @(posedge clk);
        #1;
        send_word("t4", 32'h0123_4567, 1'b1, 1'b1);
        word_valid = 1'b0;
        wait_idle("t4");
        check_writes("t4", 32'h40);

        // 5: asynchronous reset at byte_idx 2
        clear_logs();
        do_start(32'h80);
        send_word("t5", 32'hDEAD_BEEF, 1'b1, 1'b1);
        word_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_ctl", {27'd0, word_ready, wr_en, busy, done, overflow}, 32'd0);
        check_eq("t5_rst_bus", {wr_addr[23:0], wr_data}, 32'd0);
        check_eq("t5_rst_cnt", {16'd0, words_loaded}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("t5_nwr", wa_q.size(), 2);
        if (wa_q.size() == 2) check_eq("t5_b1", {wa_q[1], wd_q[1]}, {32'h81, 8'hAD});
        clear_logs();
        exp_words = '{32'h0102_0304};
        do_start(32'h0);
        send_word("t5n", 32'h0102_0304, 1'b1, 1'b1);
        word_valid = 1'b0;
        wait_idle("t5n");
        check_writes("t5n", 32'h0);

        // 6: start with word_valid in IDLE, then start pulsed mid-write
        clear_logs();
        exp_words  = '{32'hCAFE_F00D, 32'h0BAD_F00D};
        word_valid = 1'b1;
        word_data  = 32'hCAFE_F00D;
        word_last  = 1'b0;
        start      = 1'b1;
        base_addr  = 32'h100;
        @(negedge clk);
        check_eq("t6_idle_rdy", {31'd0, word_ready}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        send_word("t6a", 32'hCAFE_F00D, 1'b0, 1'b1);
        start     = 1'b1;
        base_addr = 32'h200;
        @(posedge clk);
        #1 start = 1'b0;
        send_word("t6b", 32'h0BAD_F00D, 1'b1, 1'b1);
        word_valid = 1'b0;
        wait_idle("t6");
        check_writes("t6", 32'h100);
        check_eq("t6_cnt", {16'd0, words_loaded}, 32'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
